// File: rtl/led_timebase_pkg.sv
// Shared encodings and default timing constants for the LED timebase stage.
// Rate selects, debounce states and the default step periods live here.
package led_timebase_pkg;

   localparam logic [1:0] SEL_FAST   = 2'd0;
   localparam logic [1:0] SEL_MEDIUM = 2'd1;
   localparam logic [1:0] SEL_LONG   = 2'd2;
   localparam logic [1:0] SEL_SLOW   = 2'd3;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_CHANGING = 1'b1
   } deb_state_e;

   localparam int unsigned DEF_NB_COUNTER = 32;
   localparam int unsigned DEF_LIMIT_0    = 2**23;
   localparam int unsigned DEF_LIMIT_1    = 2**24;
   localparam int unsigned DEF_LIMIT_2    = 2**25;
   localparam int unsigned DEF_LIMIT_3    = 2**26;
   localparam int unsigned DEF_DEB_CYCLES = 100000;
   localparam int unsigned DEF_NB_DEB     = 17;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a STABLE/CHANGING debounce FSM.
// o_clean follows i_raw only after the synced level has differed for DEB_CYCLES edges.
module sw_debounce
   import led_timebase_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned NB_DEB     = DEF_NB_DEB
) (
   input  logic clock,
   input  logic i_reset,
   input  logic i_raw,
   output logic o_clean
);

   localparam logic [NB_DEB-1:0] DEB_LAST = NB_DEB'(DEB_CYCLES - 1);

   logic              raw_meta_q;
   logic              raw_s_q;
   deb_state_e        state_q;
   logic [NB_DEB-1:0] cnt_q;
   logic              clean_q;

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         raw_meta_q <= 1'b0;
         raw_s_q    <= 1'b0;
      end else begin
         raw_meta_q <= i_raw;
         raw_s_q    <= raw_meta_q;
      end
   end

   // The edge that detects the difference already counts as the first stable
   // clock, so the counter is loaded with 1 on entry to CHANGING.
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         case (state_q)
            ST_STABLE: begin
               if (raw_s_q != clean_q) begin
                  state_q <= ST_CHANGING;
                  cnt_q   <= NB_DEB'(1);
               end else begin
                  cnt_q   <= '0;
               end
            end
            ST_CHANGING: begin
               if (raw_s_q == clean_q) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= ST_STABLE;
                  cnt_q   <= '0;
                  clean_q <= raw_s_q;
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_STABLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign o_clean = clean_q;

endmodule

// File: rtl/led_timebase.sv
// Step-rate generator and direction-switch conditioner feeding the LED shift block.
// o_valid pulses once per selected period; o_sw is the debounced direction level.
module led_timebase
   import led_timebase_pkg::*;
#(
   parameter int unsigned NB_COUNTER = DEF_NB_COUNTER,
   parameter int unsigned LIMIT_0    = DEF_LIMIT_0,
   parameter int unsigned LIMIT_1    = DEF_LIMIT_1,
   parameter int unsigned LIMIT_2    = DEF_LIMIT_2,
   parameter int unsigned LIMIT_3    = DEF_LIMIT_3,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned NB_DEB     = DEF_NB_DEB
) (
   input  logic       clock,
   input  logic       i_reset,
   input  logic       i_enable,
   input  logic [1:0] i_sel,
   input  logic       i_sw,
   output logic       o_valid,
   output logic       o_sw
);

   localparam logic [NB_COUNTER-1:0] TC_0 = NB_COUNTER'(LIMIT_0 - 1);
   localparam logic [NB_COUNTER-1:0] TC_1 = NB_COUNTER'(LIMIT_1 - 1);
   localparam logic [NB_COUNTER-1:0] TC_2 = NB_COUNTER'(LIMIT_2 - 1);
   localparam logic [NB_COUNTER-1:0] TC_3 = NB_COUNTER'(LIMIT_3 - 1);

   logic                  en_meta_q;
   logic                  en_s_q;
   logic [1:0]            sel_meta_q;
   logic [1:0]            sel_s_q;
   logic [NB_COUNTER-1:0] limit_m1;
   logic [NB_COUNTER-1:0] cnt_q;
   logic [NB_COUNTER-1:0] cnt_d;
   logic                  valid_q;
   logic                  valid_d;

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         en_meta_q  <= 1'b0;
         en_s_q     <= 1'b0;
         sel_meta_q <= 2'b00;
         sel_s_q    <= 2'b00;
      end else begin
         en_meta_q  <= i_enable;
         en_s_q     <= en_meta_q;
         sel_meta_q <= i_sel;
         sel_s_q    <= sel_meta_q;
      end
   end

   always_comb begin
      limit_m1 = TC_0;
      case (sel_s_q)
         SEL_FAST:   limit_m1 = TC_0;
         SEL_MEDIUM: limit_m1 = TC_1;
         SEL_LONG:   limit_m1 = TC_2;
         SEL_SLOW:   limit_m1 = TC_3;
      endcase
   end

   // >= rather than == so a switch to a shorter period while the count is
   // already past it yields one catch-up pulse instead of a full wrap.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (!en_s_q) begin
         cnt_d = '0;
      end else if (cnt_q >= limit_m1) begin
         cnt_d   = '0;
         valid_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign o_valid = valid_q;

   sw_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .NB_DEB     (NB_DEB)
   ) u_sw_deb (
      .clock   (clock),
      .i_reset (i_reset),
      .i_raw   (i_sw),
      .o_clean (o_sw)
   );

endmodule

// File: tb/tb_led_timebase.sv
// Directed bench for led_timebase with short periods (4/8/16/32) and DEB_CYCLES=5,
// followed by a randomised run against a small cycle model.
module tb_led_timebase;

   localparam int unsigned L0  = 4;
   localparam int unsigned L1  = 8;
   localparam int unsigned L2  = 16;
   localparam int unsigned L3  = 32;
   localparam int unsigned DEB = 5;

   logic       clock;
   logic       i_reset;
   logic       i_enable;
   logic [1:0] i_sel;
   logic       i_sw;
   logic       o_valid;
   logic       o_sw;

   int n_vec = 0;
   int n_err = 0;

   // model state for the randomised run
   logic        m_en0, m_en1, m_sw0, m_sw1;
   logic [1:0]  m_sel0, m_sel1;
   int unsigned m_cnt, m_run;
   logic        m_valid, m_osw;

   led_timebase #(
      .NB_COUNTER (32),
      .LIMIT_0    (L0),
      .LIMIT_1    (L1),
      .LIMIT_2    (L2),
      .LIMIT_3    (L3),
      .DEB_CYCLES (DEB),
      .NB_DEB     (3)
   ) dut (
      .clock    (clock),
      .i_reset  (i_reset),
      .i_enable (i_enable),
      .i_sel    (i_sel),
      .i_sw     (i_sw),
      .o_valid  (o_valid),
      .o_sw     (o_sw)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic reset_dut(input logic en, input logic [1:0] sel, input logic sw);
      i_reset  = 1'b1;
      i_enable = en;
      i_sel    = sel;
      i_sw     = sw;
      tick(2);
      check("rst_valid", o_valid, 0);
      check("rst_osw", o_sw, 0);
      check("rst_cnt", dut.cnt_q, 0);
      i_reset = 1'b0;
   endtask

   task automatic async_reset();
      #2 i_reset = 1'b1;
      #1;
   endtask

   function automatic int unsigned lim(input logic [1:0] s);
      case (s)
         2'd0:    return L0;
         2'd1:    return L1;
         2'd2:    return L2;
         default: return L3;
      endcase
   endfunction

   // Advances the model by one rising edge given the inputs held before it.
   task automatic model_step(input logic en, input logic [1:0] sel, input logic sw);
      if (!m_en1) begin
         m_cnt   = 0;
         m_valid = 1'b0;
      end else if (m_cnt >= lim(m_sel1) - 1) begin
         m_cnt   = 0;
         m_valid = 1'b1;
      end else begin
         m_cnt   = m_cnt + 1;
         m_valid = 1'b0;
      end
      if (m_sw1 != m_osw) begin
         m_run = m_run + 1;
         if (m_run == DEB) begin
            m_osw = m_sw1;
            m_run = 0;
         end
      end else begin
         m_run = 0;
      end
      m_en1 = m_en0;   m_en0 = en;
      m_sel1 = m_sel0; m_sel0 = sel;
      m_sw1 = m_sw0;   m_sw0 = sw;
   endtask

   initial begin
      i_reset  = 1'b1;
      i_enable = 1'b0;
      i_sel    = 2'd0;
      i_sw     = 1'b0;

      // Fastest rate from reset: first pulse 6 edges after release, then every 4
      reset_dut(1'b1, 2'd0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         tick(1);
         check("s1_valid", o_valid, (k >= 6 && (k - 2) % 4 == 0));
         check("s1_osw", o_sw, 0);
      end

      // Slowest rate, switch to sel=1 at count 20, then drop and restore enable
      reset_dut(1'b1, 2'd3, 1'b0);
      for (int k = 1; k <= 70; k++) begin
         tick(1);
         check("s23_valid", o_valid, (k == 25 || k == 33 || k == 41 || k == 65));
         if (k == 22) begin
            check("s2_cnt20", dut.cnt_q, 20);
            i_sel = 2'd1;
         end
         if (k == 46) i_enable = 1'b0;
         if (k == 55) i_enable = 1'b1;
         if (k == 56) check("s3_cnt_idle", dut.cnt_q, 0);
      end

      // Debounce: clean rise, short glitches, exactly-DEB pulse
      reset_dut(1'b0, 2'd0, 1'b0);
      tick(3);
      i_sw = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         check("s4_rise", o_sw, (k >= 7));
      end
      i_sw = 1'b0;
      tick(3);
      i_sw = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         check("s4_glitch3", o_sw, 1);
      end
      i_sw = 1'b0;
      tick(4);
      i_sw = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick(1);
         check("s4_glitch4", o_sw, 1);
      end
      i_sw = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         if (k == 5) i_sw = 1'b1;
         check("s4_pulse5", o_sw, !(k >= 7 && k < 12));
      end
      async_reset();
      check("s4_async_osw", o_sw, 0);

      // Reset mid-count and mid-debounce, then repeat the scenario-1 start
      reset_dut(1'b1, 2'd0, 1'b0);
      i_sw = 1'b1;
      tick(5);
      check("s5_cnt_pre", dut.cnt_q, 3);
      check("s5_deb_pre", dut.u_sw_deb.cnt_q, 3);
      async_reset();
      check("s5_cnt_rst", dut.cnt_q, 0);
      check("s5_deb_rst", dut.u_sw_deb.cnt_q, 0);
      check("s5_valid_rst", o_valid, 0);
      check("s5_osw_rst", o_sw, 0);
      i_sw = 1'b0;
      tick(1);
      i_reset = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick(1);
         check("s5_valid", o_valid, (k >= 6 && (k - 2) % 4 == 0));
         check("s5_osw", o_sw, 0);
      end
      async_reset();
      check("s5_async_valid", o_valid, 0);

      // Randomised select/switch/enable activity against the cycle model
      reset_dut(1'b1, 2'd0, 1'b0);
      m_en0 = 0; m_en1 = 0; m_sel0 = 0; m_sel1 = 0; m_sw0 = 0; m_sw1 = 0;
      m_cnt = 0; m_run = 0; m_valid = 0; m_osw = 0;
      begin
         logic prev_valid, prev_osw, seen_change;
         int   hold_len;
         prev_valid  = 1'b0;
         prev_osw    = 1'b0;
         seen_change = 1'b0;
         hold_len    = 0;
         for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 49) == 0)  i_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)  i_sw = ~i_sw;
            if ($urandom_range(0, 299) == 0) i_enable = ~i_enable;
            tick(1);
            model_step(i_enable, i_sel, i_sw);
            check("rnd_valid", o_valid, m_valid);
            check("rnd_osw", o_sw, m_osw);
            if (o_valid) check("rnd_width", prev_valid, 0);
            hold_len++;
            if (o_sw != prev_osw) begin
               if (seen_change) check("rnd_hold", (hold_len >= DEB), 1);
               seen_change = 1'b1;
               hold_len    = 0;
            end
            prev_valid = o_valid;
            prev_osw   = o_sw;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_timebase.md
Name: led_timebase

Overview:
- Upstream stage of the LED shift-register pattern block.
- Generates the single-cycle `o_valid` step flag at one of four switch-selected rates.
- Synchronises and debounces the raw direction switch into a clean `o_sw`.
- Both outputs connect directly to the shift-register block's `i_valid` and `i_sw` inputs.

Parameters:
- NB_COUNTER, 32, width of the rate counter.
- LIMIT_0, 2**23, period in clocks for `i_sel`=0 (fastest); must be >= 2.
- LIMIT_1, 2**24, period for `i_sel`=1.
- LIMIT_2, 2**25, period for `i_sel`=2.
- LIMIT_3, 2**26, period for `i_sel`=3 (slowest).
- DEB_CYCLES, 100000, stable clocks required before `o_sw` follows the switch; must be >= 2.
- NB_DEB, 17, width of the debounce counter; must hold DEB_CYCLES-1.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  raw run switch, asynchronous to `clock`.
- i_sel  input  2  raw rate-select switches, asynchronous to `clock`.
- i_sw  input  1  raw direction switch, asynchronous to `clock`, may bounce.
- o_valid  output  1  one-clock step pulse, registered.
- o_sw  output  1  debounced direction level, registered.

Behaviour:
- Reset: i_reset is asynchronous, active-high; clock is clock.
  - While reset is asserted: `o_valid`=0, `o_sw`=0, rate counter=0, debounce counter=0, all synchroniser flops=0.
  - Reset asserted mid-count or mid-debounce aborts it immediately.
  - No `o_valid` pulse on the first edge after reset release.
- Input synchronisation:
  - `i_enable`, `i_sel[1:0]` and `i_sw` each pass through a 2-flop synchroniser; the synced copies are `en_s`, `sel_s`, `sw_s`.
  - All downstream logic uses only the synced values, so every input has 2 clocks of latency.
- Rate counter:
  - `limit` = LIMIT_n selected by `sel_s` (combinational mux).
  - If `en_s`=0: counter <= 0, `o_valid` <= 0.
  - Else, if counter >= limit-1: counter <= 0, `o_valid` <= 1.
  - Else: counter <= counter+1, `o_valid` <= 0.
  - The compare uses >= deliberately. If `sel_s` switches to a smaller limit while the counter is already past it, exactly one pulse fires on the next edge, then the new period applies. No wrap-around through 2**NB_COUNTER.
  - Steady state: `o_valid` high exactly 1 clock in every `limit` clocks. The first pulse appears `limit` edges after `en_s` rises.
  - `en_s` falling on the same edge the terminal count is reached suppresses the pulse (enable has priority).
- Debounce (2-state: STABLE, CHANGING):
  - STABLE: `sw_s`==`o_sw`; deb counter held at 0. Goes to CHANGING when `sw_s`!=`o_sw`.
  - CHANGING: if `sw_s`==`o_sw` (bounce back), deb counter <= 0 and return to STABLE, with `o_sw` unchanged.
    - Else if deb counter == DEB_CYCLES-1: `o_sw` <= `sw_s`, deb counter <= 0, go to STABLE.
    - Else: deb counter increments.
  - A clean edge on `i_sw` appears on `o_sw` exactly 2+DEB_CYCLES clock edges later.
  - Any glitch shorter than DEB_CYCLES clocks never reaches `o_sw`.
- Independence: `o_sw` may change on the same edge `o_valid` pulses. The downstream block samples both together, so no ordering between them is required.

Decomposition:
- Shared package holds:
  - rate-select encoding constants SEL_FAST=2'd0 … SEL_SLOW=2'd3;
  - debounce state encoding ST_STABLE/ST_CHANGING;
  - default LIMIT_* values.
- One natural sub-module: `sw_debounce` (2-flop sync + debounce FSM, parameters DEB_CYCLES/NB_DEB, ports clock, i_reset, i_raw, o_clean).
  - Instantiated once for `i_sw`.
- The enable/select synchronisers and the rate counter stay in the top module.

Test Plan (LIMIT_0..3 = 4, 8, 16, 32; DEB_CYCLES=5):
1. Reset, `i_enable`=1, `i_sel`=0, hold 40 clocks → first `o_valid` pulse 6 edges after reset release (2 sync + 4), then 1-clock pulses every 4 clocks; `o_sw`=0 throughout.
2. `i_sel`=3, wait until counter is 20, then set `i_sel`=1 → one pulse 3 edges after the `i_sel` change (2-cycle sync, then 1 edge since counter>=7), then period 8.
3. Drop `i_enable` on the cycle the synced terminal count would fire → no pulse; counter 0; on re-enable, first pulse 8 edges after `en_s` rises (`i_sel`=1).
4. `i_sw` 0→1 held → `o_sw` rises exactly 7 edges after the change. Then `i_sw` 1→0 for 3 clocks and back to 1 → `o_sw` stays 1.
5. Assert `i_reset` mid-debounce (deb counter=3) and mid-count → outputs and counters 0 immediately (asynchronously); after release, behaviour matches scenario 1.
6. Random `i_sel`/`i_sw` changes over 10k clocks vs. reference model → every `o_valid` is exactly 1 clock wide; gaps between pulses are never shorter than the smaller of the old and new limits, except the single catch-up pulse after a limit decrease; `o_sw` never holds a value shorter than DEB_CYCLES.
